// File: rtl/uacc_pkg.sv
// Shared types and constants for the uacc_5 sample accumulator.
package uacc_pkg;

   localparam int IN_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } uacc_state_t;

endpackage

// File: rtl/usat_add_w.sv
// Unsigned W-bit + IN_W-bit adder that clamps to all ones on carry-out.
module usat_add_w
   import uacc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0]    i_a,
   input  logic [IN_W-1:0] i_b,
   output logic [W-1:0]    o_sum,
   output logic            o_sat
);

   logic [W:0] w_full;

   always_comb begin
      w_full = {1'b0, i_a} + {{(W + 1 - IN_W){1'b0}}, i_b};
      if (w_full[W]) begin
         o_sum = {W{1'b1}};
         o_sat = 1'b1;
      end else begin
         o_sum = w_full[W-1:0];
         o_sat = 1'b0;
      end
   end

endmodule

// File: rtl/uacc_5.sv
// Accumulates N_SAMPLES upstream adder results into a saturating ACC_W-bit
// sum and hands it downstream with a valid/ready handshake.
module uacc_5
   import uacc_pkg::*;
#(
   parameter int N_SAMPLES = 4,
   parameter int ACC_W     = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [IN_W-1:0]  i_in_data,
   input  logic             i_in_of,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ACC_W-1:0] o_out_sum,
   output logic             o_out_sat,
   output logic             o_out_of
);

   localparam int                CNT_W    = $clog2(N_SAMPLES + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_SAMPLES - 1);

   uacc_state_t      r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;
   logic             r_of;
   logic [ACC_W-1:0] w_sum;
   logic             w_sat;

   usat_add_w #(
      .W (ACC_W)
   ) u_add (
      .i_a   (r_acc),
      .i_b   (i_in_data),
      .o_sum (w_sum),
      .o_sat (w_sat)
   );

   // Run FSM with accumulator, sample counter and sticky flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_acc   <= {ACC_W{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
         r_sat   <= 1'b0;
         r_of    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_acc   <= {ACC_W{1'b0}};
                  r_cnt   <= {CNT_W{1'b0}};
                  r_sat   <= 1'b0;
                  r_of    <= 1'b0;
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               if (i_in_valid) begin
                  r_acc <= w_sum;
                  r_sat <= r_sat | w_sat;
                  r_of  <= r_of | i_in_of | w_sat;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Result values stay put after the handshake until the next start.
               if (i_out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = (r_state == ACCUM);
   assign o_out_valid = (r_state == HOLD);
   assign o_out_sum   = r_acc;
   assign o_out_sat   = r_sat;
   assign o_out_of    = r_of;

endmodule

// File: tb/tb_uacc_5.sv
// Scoreboard bench for uacc_5: a default instance (N=4) and an N=10 instance
// share one stimulus bus and are selected by separate start pulses.
module tb_uacc_5;

   typedef struct packed {
      logic [7:0] sum;
      logic       sat;
      logic       of;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_of;
   logic       out_ready;

   logic       a_in_ready, a_out_valid, a_out_sat, a_out_of;
   logic [7:0] a_out_sum;
   logic       b_in_ready, b_out_valid, b_out_sat, b_out_of;
   logic [7:0] b_out_sum;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [4:0] s_d[16];
   logic       s_of[16];
   int         s_gap[16];
   int         hold_cycles;
   bit         start_noise;

   always #5 clk = ~clk;

   uacc_5 #(.N_SAMPLES(4), .ACC_W(8)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_in_valid(in_valid),
      .o_in_ready(a_in_ready), .i_in_data(in_data), .i_in_of(in_of),
      .o_out_valid(a_out_valid), .i_out_ready(out_ready),
      .o_out_sum(a_out_sum), .o_out_sat(a_out_sat), .o_out_of(a_out_of)
   );

   uacc_5 #(.N_SAMPLES(10), .ACC_W(8)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_in_valid(in_valid),
      .o_in_ready(b_in_ready), .i_in_data(in_data), .i_in_of(in_of),
      .o_out_valid(b_out_valid), .i_out_ready(out_ready),
      .o_out_sum(b_out_sum), .o_out_sat(b_out_sat), .o_out_of(b_out_of)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: compare whenever a result is presented, retire it on handshake.
   always @(negedge clk) begin
      if (!rst && a_out_valid) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_unexpected_result: out_valid=1 with no result pending (t=%0t)", $time);
         end else begin
            chk("a_out_sum", a_out_sum, q_a[0].sum);
            chk("a_out_sat", a_out_sat, q_a[0].sat);
            chk("a_out_of", a_out_of, q_a[0].of);
            if (out_ready) q_a.delete(0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_out_valid) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_unexpected_result: out_valid=1 with no result pending (t=%0t)", $time);
         end else begin
            chk("b_out_sum", b_out_sum, q_b[0].sum);
            chk("b_out_sat", b_out_sat, q_b[0].sat);
            chk("b_out_of", b_out_of, q_b[0].of);
            if (out_ready) q_b.delete(0);
         end
      end
   end

   task automatic set_start(input bit which, input logic v);
      if (which) start_b = v;
      else start_a = v;
   endtask

   // Reference: saturation is monotonic for unsigned adds, so the run result
   // is simply min(total, 255); sticky overflow is any upstream flag or clamp.
   function automatic exp_t model(input int n);
      int   total = 0;
      bit   anyof = 1'b0;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         total += int'(s_d[i]);
         anyof |= s_of[i];
      end
      e.sat = (total > 255);
      e.sum = e.sat ? 8'd255 : 8'(total);
      e.of  = anyof | e.sat;
      return e;
   endfunction

   task automatic run(input bit which);
      int   n = which ? 10 : 4;
      exp_t e = model(n);
      if (which) q_b.push_back(e);
      else q_a.push_back(e);
      @(posedge clk); #1;
      set_start(which, 1'b1);
      @(posedge clk); #1;
      set_start(which, 1'b0);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < s_gap[i]; g++) begin
            in_valid = 1'b0;
            in_data  = 5'($urandom);
            in_of    = 1'($urandom);
            set_start(which, start_noise ? 1'($urandom) : 1'b0);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = s_d[i];
         in_of    = s_of[i];
         set_start(which, start_noise ? 1'($urandom) : 1'b0);
         @(negedge clk);
         chk("in_ready_accum", which ? b_in_ready : a_in_ready, 1);
         chk("out_valid_accum", which ? b_out_valid : a_out_valid, 0);
         @(posedge clk); #1;
         in_valid = 1'b0;
         set_start(which, 1'b0);
      end
      @(negedge clk);
      chk("latency_out_valid", which ? b_out_valid : a_out_valid, 1);
      chk("hold_in_ready", which ? b_in_ready : a_in_ready, 0);
      for (int h = 0; h < hold_cycles; h++) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         in_data  = 5'($urandom);
         set_start(which, start_noise ? 1'($urandom) : 1'b0);
         @(negedge clk);
         chk("backpressure_out_valid", which ? b_out_valid : a_out_valid, 1);
         chk("backpressure_in_ready", which ? b_in_ready : a_in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_start(which, start_noise);
      @(posedge clk); #1;
      out_ready = 1'b0;
      set_start(which, 1'b0);
      @(negedge clk);
      chk("idle_out_valid", which ? b_out_valid : a_out_valid, 0);
      chk("idle_in_ready", which ? b_in_ready : a_in_ready, 0);
      chk("retained_sum", which ? b_out_sum : a_out_sum, e.sum);
      chk("retained_of", which ? b_out_of : a_out_of, e.of);
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_restart_in_ready", which ? b_in_ready : a_in_ready, 0);
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 16; i++) begin
         s_d[i]   = 5'd0;
         s_of[i]  = 1'b0;
         s_gap[i] = 0;
      end
      hold_cycles = 0;
      start_noise = 1'b0;
   endtask

   task automatic rand_stim();
      for (int i = 0; i < 16; i++) begin
         s_d[i]   = 5'($urandom);
         s_of[i]  = ($urandom_range(0, 7) == 0);
         s_gap[i] = $urandom_range(0, 2);
      end
      hold_cycles = $urandom_range(0, 3);
      start_noise = 1'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
      in_data = 5'd0; in_of = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_sum", a_out_sum, 0);
      chk("rst_a_out_sat", a_out_sat, 0);
      chk("rst_a_out_of", a_out_of, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
      chk("rst_b_out_sum", b_out_sum, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 10+20+30+31 = 91, no overflow.
      clear_stim();
      s_d[0] = 5'd10; s_d[1] = 5'd20; s_d[2] = 5'd30; s_d[3] = 5'd31;
      run(1'b0);

      // Upstream overflow on third sample only: 34, of=1.
      clear_stim();
      s_d[0] = 5'd1; s_d[1] = 5'd2; s_d[2] = 5'd31; s_d[3] = 5'd0; s_of[2] = 1'b1;
      run(1'b0);

      // Valid gap of 3, 5 cycles of backpressure, start noise everywhere.
      clear_stim();
      s_d[0] = 5'd7; s_d[1] = 5'd8; s_d[2] = 5'd9; s_d[3] = 5'd10; s_gap[2] = 3;
      hold_cycles = 5;
      start_noise = 1'b1;
      run(1'b0);

      // N=10: ten samples of 31 clamp at sample 9 to 255.
      clear_stim();
      for (int i = 0; i < 10; i++) s_d[i] = 5'd31;
      run(1'b1);

      // Reset mid-run after 25+25 = 50; partial run must vanish.
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      in_valid = 1'b1; in_data = 5'd25; in_of = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", a_in_ready, 0);
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_out_sum", a_out_sum, 0);
      chk("midrst_out_of", a_out_of, 0);
      clear_stim();
      for (int i = 0; i < 4; i++) s_d[i] = 5'd5;
      run(1'b0);

      for (int r = 0; r < 12; r++) begin
         rand_stim();
         run(1'b0);
      end
      for (int r = 0; r < 4; r++) begin
         rand_stim();
         run(1'b1);
      end

      repeat (2) @(posedge clk);
      chk("a_results_drained", q_a.size(), 0);
      chk("b_results_drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uacc_5.md
Name: uacc_5

Overview:
- Downstream consumer of the 5-bit saturating adder stage.
- Takes its 5-bit sum `s` and overflow flag `of`, and accumulates a fixed number of samples into a wider unsigned register with integer saturation.
- Presents the result with a valid/ready handshake, plus a sticky overflow indication (upstream overflow OR accumulator saturation).
- Accumulation runs are framed by a `start` pulse.

Parameters:
- N_SAMPLES, 4, samples accumulated per run; legal range >= 1.
- ACC_W, 8, accumulator/result width in bits; legal range >= 5.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begins a run; honoured only in IDLE
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  5  unsigned sample (adder `s`)
- in_of  input  1  upstream overflow flag (adder `of`), qualified by in_valid
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_W  saturated unsigned accumulation result
- out_sat  output  1  accumulator saturated during the run
- out_of  output  1  sticky: any accepted in_of=1, or out_sat

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state is updated on the rising edge of `clk`.
- Reset values: state=IDLE, acc=0, cnt=0, sat=0, of=0. Therefore in_ready=0, out_valid=0, out_sum=0, out_sat=0, out_of=0.
- Reset mid-run: reset asserted in any state wins over all other inputs. The partial run is discarded; no result is produced.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> next cycle: acc=0, cnt=0, sat=0, of=0; go to ACCUM.
- ACCUM:
  - in_ready=1; a sample is accepted when in_valid=1.
  - On accept:
    - acc_next = sat(acc + in_data), computed at ACC_W+1 bits. If bit ACC_W is set, acc_next = all ones and sat := 1.
    - of := of | in_of | saturation event.
    - cnt := cnt + 1.
  - If the accepted sample is sample number N_SAMPLES (cnt == N_SAMPLES-1 before the update) -> go to HOLD.
  - No accept -> all state is held.
  - start is ignored.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_sum, out_sat and out_of are stable and registered.
  - out_ready=1 -> go to IDLE next cycle; outputs keep their final values until the next start clears them.
  - start is ignored, including when it coincides with the out_ready handshake.
- Latency: out_valid rises one cycle after the last sample is accepted. Minimum run length is 1 (start) + N_SAMPLES + 1 cycles.
- Once sat=1 it stays set. acc remains all ones for the rest of the run; further additions cannot wrap.
- in_data/in_of are don't-care when in_valid=0 or in_ready=0.
- cnt width is $clog2(N_SAMPLES+1). cnt never wraps within a run.
- Output signals are driven from registers only; there is no combinational path from input to output except in_ready and out_valid, which decode the state register.

Decomposition:
- Package `uacc_pkg`:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} uacc_state_t
  - localparam IN_W = 5
- Sub-module `usat_add_w` (parameter W): combinational unsigned W-bit + IN_W-bit add with saturation.
  - Outputs: W-bit sum and a sat flag.
  - Instantiated once for the accumulator datapath.
- The FSM, counter and sticky flags stay in `uacc_5`.

Test Plan:
- Defaults (N=4, ACC_W=8): start, then samples 10, 20, 30, 31 with in_of=0 -> out_valid one cycle after the 4th accept; out_sum=91, out_sat=0, out_of=0.
- N=10, ACC_W=8: ten samples of 31 -> running sum hits 255 at sample 9; out_sum=255, out_sat=1, out_of=1.
- Defaults: samples 1, 2, 31, 0 with in_of=1 on the third sample -> out_sum=34, out_sat=0, out_of=1.
- Backpressure and valid gaps:
  - in_valid low for 3 cycles between samples -> cnt unchanged; final sum correct.
  - out_ready low for 5 cycles in HOLD -> out_valid stays 1, outputs stable, in_ready=0.
  - Then out_ready=1 -> IDLE.
- Reset mid-run: after 2 of 4 samples (sum 50), assert rst for 1 cycle -> all outputs 0, state IDLE. A new start with 4×5 -> out_sum=20.
- Ignored start:
  - start pulses during ACCUM -> no clear; sum unaffected.
  - start in HOLD while out_ready=1 -> goes to IDLE only; a new run requires a fresh start.
